radix4_unsigned_divider: RTL and testbench



---
 rtl/radix4_unsigned_divider.sv | 160 ++++++++++++++++
 tb/tb_radix4_unsigned_divider.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_unsigned_divider.sv
// Iterative radix-4 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// two quotient bits per clock, with divide-by-zero and overflow screening at accept.
module radix4_unsigned_divider #(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int TW    = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;   // partial remainder, final remainder in DONE
  logic [WIDTH-1:0]   shf_q, shf_d;   // dividend low half shifts out, quotient shifts in
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  logic [TW-1:0]      trial;
  logic [TW-1:0]      d1, d2, d3;
  logic [TW-1:0]      sub;
  logic [TW-1:0]      diff;
  logic [1:0]         qdig;

  // One radix-4 step: pick the largest multiple of the divisor that fits.
  assign trial = {rem_q, shf_q[WIDTH-1:WIDTH-2]};
  assign d1    = {2'b00, dsr_q};
  assign d2    = {1'b0, dsr_q, 1'b0};
  assign d3    = d1 + d2;

  always_comb begin
    if (trial >= d3) begin
      qdig = 2'd3;
      sub  = d3;
    end else if (trial >= d2) begin
      qdig = 2'd2;
      sub  = d2;
    end else if (trial >= d1) begin
      qdig = 2'd1;
      sub  = d1;
    end else begin
      qdig = 2'd0;
      sub  = '0;
    end
  end

  assign diff = trial - sub;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    rem_d   = rem_q;
    shf_d   = shf_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dsr_d = divisor;
          cnt_d = '0;
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            shf_d   = '1;
            rem_d   = dividend[WIDTH-1:0];
            state_d = DONE;
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            shf_d   = '1;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            rem_d   = dividend[2*WIDTH-1:WIDTH];
            shf_d   = dividend[WIDTH-1:0];
            state_d = ITER;
          end
        end
      end

      ITER: begin
        rem_d = diff[WIDTH-1:0];
        shf_d = {shf_q[WIDTH-3:0], qdig};
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the datapath registers are reset alongside the FSM
  // because their values are architecturally visible on the result ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      shf_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shf_q   <= shf_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Restoring invariant: the new partial remainder is below the divisor.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ITER) assert (diff[TW-1:WIDTH] == 2'b00);
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = shf_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_radix4_unsigned_divider.sv
// Randomized and directed bench for radix4_unsigned_divider against an
// arithmetic reference model (plain / and % on 64-bit integers).
module tb_radix4_unsigned_divider;

  localparam int W     = 12;
  localparam int STEPS = W / 2;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } exp_t;

  radix4_unsigned_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t ref_div(input logic [2*W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned aa = longint'(a);
    longint unsigned bb = longint'(b);
    longint unsigned lim = longint'(1) << W;
    if (bb == 0) begin
      e.dz = 1'b1; e.ov = 1'b0; e.q = '1; e.r = a[W-1:0];
    end else if (aa / bb >= lim) begin
      e.dz = 1'b0; e.ov = 1'b1; e.q = '1; e.r = '0;
    end else begin
      e.dz = 1'b0; e.ov = 1'b0; e.q = W'(aa / bb); e.r = W'(aa % bb);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string name, input exp_t e);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
      errors++;
      $display("FAIL %s: got q=%0h r=%0h dz=%0b ov=%0b required q=%0h r=%0h dz=%0b ov=%0b",
               name, quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dz, e.ov);
    end
  endtask

  // Accepts one operation, returns the number of edges after the accept edge
  // until out_valid is seen (bounded), and whether in_ready stayed low meanwhile.
  task automatic issue_and_wait(input logic [2*W-1:0] a, input logic [W-1:0] b,
                                output int lat, output bit busy_ok);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dividend = 2*W'($urandom);
    divisor  = W'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b, input string name);
    exp_t e = ref_div(a, b);
    int   exp_lat = (e.dz || e.ov) ? 0 : STEPS;
    int   lat;
    bit   busy_ok;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: in_ready=%0b required 1", name, in_ready);
    end
    issue_and_wait(a, b, lat, busy_ok);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges required %0d", name, lat, exp_lat);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy: in_ready was 1 during iteration, required 0", name);
    end
    check_result(name, e);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: out_valid=%0b in_ready=%0b required 0/1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !==
        {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b q=%0h r=%0h dz=%0b ov=%0b required 1 0 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_directed();
    run_op(24'd1000000, 12'd1000, "div_1e6_by_1000");
    run_op(24'h3FFFFF,  12'd4095, "div_max_by_4095");
    run_op(24'd0,       12'd7,    "div_zero_by_7");
    run_op(24'd5,       12'd0,    "div_by_zero");
    run_op(24'h123456,  12'h123,  "overflow_equal_high");
    run_op(24'hFFFFFF,  12'hFFF,  "overflow_all_ones");
    run_op(24'hFFEFFF,  12'hFFF,  "high_just_below");
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] a = 24'h0ABCDE;
    logic [W-1:0]   b = 12'h321;
    exp_t e = ref_div(a, b);
    int   lat;
    bit   busy_ok;
    bit   stable_ok = 1'b1;
    issue_and_wait(a, b, lat, busy_ok);
    checks++;
    if (lat != STEPS) begin
      errors++;
      $display("FAIL bp latency: got %0d edges required %0d", lat, STEPS);
    end
    check_result("bp_result", e);
    dividend = 24'd5;
    divisor  = 12'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          quotient !== e.q || remainder !== e.r) stable_ok = 1'b0;
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL bp_hold: vld=%0b rdy=%0b q=%0h r=%0h required 1 0 %0h %0h",
               out_valid, in_ready, quotient, remainder, e.q, e.r);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_not_queued: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_iter();
    dividend = 24'h456789;
    divisor  = 12'hABC;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !==
        {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_iter: rdy=%0b vld=%0b q=%0h r=%0h dz=%0b ov=%0b required 1 0 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    run_op(24'd1000000, 12'd1000, "after_reset");
  endtask

  task automatic gen_operands(output logic [2*W-1:0] a, output logic [W-1:0] b);
    logic [W-1:0] hi;
    logic [W-1:0] lo = W'($urandom);
    int           cat = $urandom_range(0, 9);
    case (cat)
      0: begin b = '0; hi = W'($urandom); end
      1: begin b = 12'd1; hi = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0; end
      2: begin b = 12'd4095; hi = W'($urandom_range(0, 4094)); end
      3: begin b = W'($urandom_range(1, 4095)); hi = b - 1'b1; end
      4: begin b = W'($urandom_range(1, 4095)); hi = W'($urandom_range(int'(b), 4095)); end
      default: begin b = W'($urandom_range(1, 4095)); hi = W'($urandom % int'(b)); end
    endcase
    a = {hi, lo};
  endtask

  task automatic test_back_to_back(input int n);
    exp_t           pend[$];
    exp_t           e;
    int             issued = 0;
    int             cyc = 0;
    logic           acc;
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    out_ready = 1'b1;
    gen_operands(a, b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while ((issued < n || pend.size() > 0) && cyc < n * 12) begin
      acc = in_ready & in_valid;
      if (out_valid) begin
        if (pend.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_spurious: out_valid=1 with no operation outstanding");
        end else begin
          e = pend.pop_front();
          check_result("rand_result", e);
        end
      end
      if (acc) begin
        pend.push_back(ref_div(a, b));
        issued++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (issued < n) begin
          gen_operands(a, b);
          dividend = a;
          divisor  = b;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (issued != n || pend.size() != 0) begin
      errors++;
      $display("FAIL rand_timeout: issued %0d of %0d, %0d outstanding, required all done",
               issued, n, pend.size());
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_iter();
    test_back_to_back(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
